// File: rtl/spi_ufi_pkg.sv
// Shared definitions for the SPI-to-UFI burst write path.
//   cUfiWrCmd        : SPI command code that selects a UFI write burst
//   cAdrsStepDefault : default byte increment between consecutive burst words
//   seqState_t       : burst sequencer state encoding
package spi_ufi_pkg;

  localparam logic [1:0]  cUfiWrCmd        = 2'b11;
  localparam int unsigned cAdrsStepDefault = 4;

  typedef enum logic [1:0] {
    sIdle  = 2'b00,
    sRun   = 2'b01,
    sAbort = 2'b10
  } seqState_t;

endpackage

// File: rtl/ufi_wr_fifo.sv
// Synchronous 32-bit FIFO buffering SPI words ahead of the UFI write bus.
//   iSysClk/iSysRst : clock, asynchronous active-high reset
//   push/din        : write a word (ignored when full unless popping the same cycle)
//   pop/dout        : dout is the head word (0 when empty); pop advances past it
//   flush           : synchronous discard of all contents
//   full/empty      : occupancy flags
module ufi_wr_fifo #(
  parameter int unsigned pFifoDepth = 8
) (
  input  logic        iSysClk,
  input  logic        iSysRst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int unsigned cPtrW = $clog2(pFifoDepth);

  logic [31:0]    mem [pFifoDepth];
  logic [cPtrW:0] wrPtr;
  logic [cPtrW:0] rdPtr;
  logic           doPush;
  logic           doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[cPtrW-1:0] == rdPtr[cPtrW-1:0]) && (wrPtr[cPtrW] != rdPtr[cPtrW]);
  assign doPop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot this cycle, so the write may reuse it.
  assign doPush = push & (~full | doPop);
  assign dout   = empty ? '0 : mem[rdPtr[cPtrW-1:0]];

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge iSysClk) begin
    if (doPush && !flush) mem[wrPtr[cPtrW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_ufi_burst_sequencer.sv
// Sequences SPI-slave UFI write bursts onto the UFI master write bus.
//   iSysClk, iSysRst        : clock, asynchronous active-high reset
//   iSRd/iSAdrs/iSCmd/iSRdVd: SPI word, burst base address, command, strobe
//   iSDLen                  : burst word count, 0 when SPI idle (aborts an open burst)
//   iMUfiRdy                : UFI slave ready
//   oMUfiWd/oMUfiAdrs       : UFI write data/address, stable while stalled
//   oMUfiWEd                : write valid; transfer on oMUfiWEd & iMUfiRdy
//   oMUfiWVd                : burst window (RUN state)
//   oSBusy, oSDone          : not idle; one-cycle pulse after the last accepted word
//   oSOvf, oSErr            : sticky overflow / abort flags, cleared at burst start
module spi_ufi_burst_sequencer
  import spi_ufi_pkg::*;
#(
  parameter int unsigned pFifoDepth = 8,
  parameter int unsigned pAdrsStep  = cAdrsStepDefault
) (
  input  logic        iSysClk,
  input  logic        iSysRst,
  input  logic [31:0] iSRd,
  input  logic [31:0] iSAdrs,
  input  logic [1:0]  iSCmd,
  input  logic [15:0] iSDLen,
  input  logic        iSRdVd,
  input  logic        iMUfiRdy,
  output logic [31:0] oMUfiWd,
  output logic [31:0] oMUfiAdrs,
  output logic        oMUfiWEd,
  output logic        oMUfiWVd,
  output logic        oSBusy,
  output logic        oSDone,
  output logic        oSOvf,
  output logic        oSErr
);

  localparam logic [31:0] cStep = 32'(pAdrsStep);

  seqState_t   state, stateNxt;
  logic [31:0] base;
  logic [15:0] len, rxCnt, txCnt, dropCnt;
  logic        doneQ, ovfQ, errQ;

  logic        pushEv, startEv, abortEv, runPush, dropEv, xferEv, lastEv;
  logic        fifoPush, fifoFull, fifoEmpty;
  logic [31:0] fifoDout;

  assign pushEv  = iSRdVd && (iSCmd == cUfiWrCmd);
  assign startEv = (state == sIdle) && pushEv && (iSDLen != '0);
  assign abortEv = (state == sRun) && (iSDLen == '0) && (rxCnt < len);
  assign runPush = (state == sRun) && pushEv && (rxCnt < len) && !abortEv;
  assign xferEv  = oMUfiWEd && iMUfiRdy;
  assign dropEv  = runPush && fifoFull && !xferEv;
  // Dropped words never reach the bus, so the burst completes after len-dropCnt transfers.
  assign lastEv  = xferEv && !abortEv &&
                   (({1'b0, txCnt} + 17'd1) == ({1'b0, len} - {1'b0, dropCnt}));
  assign fifoPush = startEv || (runPush && !dropEv);

  ufi_wr_fifo #(.pFifoDepth(pFifoDepth)) uFifo (
    .iSysClk (iSysClk),
    .iSysRst (iSysRst),
    .push    (fifoPush),
    .pop     (xferEv),
    .flush   (abortEv),
    .din     (iSRd),
    .dout    (fifoDout),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) state <= sIdle;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt  = state;
    oMUfiWEd  = 1'b0;
    oMUfiWVd  = 1'b0;
    oSBusy    = 1'b1;
    case (state)
      sIdle: begin
        oSBusy = 1'b0;
        if (startEv) stateNxt = sRun;
      end
      sRun: begin
        oMUfiWVd = 1'b1;
        oMUfiWEd = !fifoEmpty;
        if (abortEv)     stateNxt = sAbort;
        else if (lastEv) stateNxt = sIdle;
      end
      sAbort:  stateNxt = sIdle;
      default: stateNxt = sIdle;
    endcase
  end

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      base    <= '0;
      len     <= '0;
      rxCnt   <= '0;
      txCnt   <= '0;
      dropCnt <= '0;
      doneQ   <= 1'b0;
      ovfQ    <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      doneQ <= lastEv;
      if (startEv) begin
        base    <= iSAdrs;
        len     <= iSDLen;
        rxCnt   <= 16'd1;
        txCnt   <= '0;
        dropCnt <= '0;
        ovfQ    <= 1'b0;
        errQ    <= 1'b0;
      end else begin
        if (runPush) rxCnt <= rxCnt + 16'd1;
        if (dropEv) begin
          dropCnt <= dropCnt + 16'd1;
          ovfQ    <= 1'b1;
        end
        if (xferEv)  txCnt <= txCnt + 16'd1;
        if (abortEv) errQ  <= 1'b1;
      end
    end
  end

  assign oMUfiWd   = fifoDout;
  assign oMUfiAdrs = base + (32'(txCnt) * cStep);
  assign oSDone    = doneQ;
  assign oSOvf     = ovfQ;
  assign oSErr     = errQ;

endmodule

// File: tb/tb_spi_ufi_burst_sequencer.sv
module tb_spi_ufi_burst_sequencer;

  localparam int cDepth = 8;
  localparam int cStep  = 4;

  logic        iSysClk = 1'b0;
  logic        iSysRst;
  logic [31:0] iSRd, iSAdrs;
  logic [1:0]  iSCmd;
  logic [15:0] iSDLen;
  logic        iSRdVd, iMUfiRdy;
  logic [31:0] oMUfiWd, oMUfiAdrs;
  logic        oMUfiWEd, oMUfiWVd, oSBusy, oSDone, oSOvf, oSErr;

  always #5 iSysClk = ~iSysClk;

  spi_ufi_burst_sequencer #(.pFifoDepth(cDepth), .pAdrsStep(cStep)) dut (
    .iSysClk(iSysClk), .iSysRst(iSysRst), .iSRd(iSRd), .iSAdrs(iSAdrs),
    .iSCmd(iSCmd), .iSDLen(iSDLen), .iSRdVd(iSRdVd), .iMUfiRdy(iMUfiRdy),
    .oMUfiWd(oMUfiWd), .oMUfiAdrs(oMUfiAdrs), .oMUfiWEd(oMUfiWEd),
    .oMUfiWVd(oMUfiWVd), .oSBusy(oSBusy), .oSDone(oSDone),
    .oSOvf(oSOvf), .oSErr(oSErr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: burst phase, a queue of buffered words, and transfer/drop tallies.
  int          mSt;   // 0 idle, 1 burst running, 2 abort
  logic [31:0] mBase;
  int          mLen, mRx, mTx, mDrops;
  logic [31:0] mQ[$];
  bit          mOvf, mErr, mDone;

  // Log of transfers observed on the bus.
  logic [31:0] logAdrs[$];
  logic [31:0] logData[$];
  int          doneCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mSt = 0; mBase = '0; mLen = 0; mRx = 0; mTx = 0; mDrops = 0;
    mQ.delete(); mOvf = 0; mErr = 0; mDone = 0;
  endtask

  task automatic modelEdge(input bit vd, input logic [1:0] cmd, input logic [15:0] dlen,
                           input logic [31:0] adrs, input logic [31:0] rd, input bit rdy);
    bit p, pop, fin, doneNxt;
    int occ;
    p = vd && (cmd == 2'b11);
    doneNxt = 0;
    case (mSt)
      0: if (p && dlen != 0) begin
        mBase = adrs; mLen = int'(dlen); mRx = 1; mTx = 0; mDrops = 0;
        mQ.delete(); mQ.push_back(rd); mOvf = 0; mErr = 0; mSt = 1;
      end
      2: mSt = 0;
      default: begin
        pop = (mQ.size() > 0) && rdy;
        if (dlen == 0 && mRx < mLen) begin
          mQ.delete(); mErr = 1; mSt = 2;
        end else begin
          fin = pop && (mTx + 1 == mLen - mDrops);
          occ = mQ.size();
          if (p && mRx < mLen) begin
            mRx++;
            if (occ == cDepth && !pop) begin mDrops++; mOvf = 1; end
            else mQ.push_back(rd);
          end
          if (pop) begin void'(mQ.pop_front()); mTx++; end
          if (fin) begin mSt = 0; doneNxt = 1; end
        end
      end
    endcase
    mDone = doneNxt;
  endtask

  task automatic checkOut();
    bit wed;
    logic [31:0] a;
    wed = (mSt == 1) && (mQ.size() > 0);
    chk("busy", oSBusy, mSt != 0);
    chk("wvd", oMUfiWVd, mSt == 1);
    chk("wed", oMUfiWEd, wed);
    chk("done", oSDone, mDone);
    chk("ovf", oSOvf, mOvf);
    chk("err", oSErr, mErr);
    if (wed) begin
      a = mBase + 32'(mTx * cStep);
      chk("wd", oMUfiWd, mQ[0]);
      chk("adrs", oMUfiAdrs, a);
    end
  endtask

  // Called at a negedge: drive inputs, advance the model over the next posedge, check after it.
  task automatic tick(input bit vd, input logic [1:0] cmd, input logic [15:0] dlen,
                      input logic [31:0] adrs, input logic [31:0] rd, input bit rdy);
    iSRdVd = vd; iSCmd = cmd; iSDLen = dlen; iSAdrs = adrs; iSRd = rd; iMUfiRdy = rdy;
    #1;
    if (oMUfiWEd && rdy) begin
      logAdrs.push_back(oMUfiAdrs);
      logData.push_back(oMUfiWd);
    end
    modelEdge(vd, cmd, dlen, adrs, rd, rdy);
    @(negedge iSysClk);
    if (oSDone) doneCnt++;
    checkOut();
  endtask

  task automatic finishBurst(input string name);
    int n;
    n = 0;
    while (mSt != 0 && n < 60) begin
      tick(0, 2'b11, 16'(mLen), '0, '0, 1);
      n++;
    end
    checks++;
    if (mSt != 0) begin
      failures++;
      $display("FAIL %s_timeout: burst still open after %0d cycles", name, n);
    end
  endtask

  typedef struct {
    bit          vd;
    logic [1:0]  cmd;
    logic [15:0] dlen;
    logic [31:0] adrs, rd;
    bit          rdy;
    bit          eWEd, eWVd, eDone;
    logic [31:0] eAdrs, eWd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d0, len, ab, n;
    logic [31:0] base;
    logic [15:0] dl;
    bit vd;

    // Burst of four at 0x1000, then foreign-command strobes and a zero-length strobe.
    tbl[0] = '{1, 2'b11, 16'd4, 32'h1000, 32'hA0, 1, 1, 1, 0, 32'h1000, 32'hA0};
    tbl[1] = '{1, 2'b11, 16'd4, 32'h0,    32'hA1, 1, 1, 1, 0, 32'h1004, 32'hA1};
    tbl[2] = '{1, 2'b11, 16'd4, 32'h0,    32'hA2, 1, 1, 1, 0, 32'h1008, 32'hA2};
    tbl[3] = '{1, 2'b11, 16'd4, 32'h0,    32'hA3, 1, 1, 1, 0, 32'h100C, 32'hA3};
    tbl[4] = '{0, 2'b11, 16'd4, 32'h0,    32'h0,  1, 0, 0, 1, 32'h0,    32'h0};
    tbl[5] = '{0, 2'b11, 16'd0, 32'h0,    32'h0,  1, 0, 0, 0, 32'h0,    32'h0};
    tbl[6] = '{1, 2'b01, 16'd4, 32'h2000, 32'h55, 1, 0, 0, 0, 32'h0,    32'h0};
    tbl[7] = '{1, 2'b01, 16'd4, 32'h2000, 32'h66, 1, 0, 0, 0, 32'h0,    32'h0};
    tbl[8] = '{1, 2'b11, 16'd0, 32'h2000, 32'h77, 1, 0, 0, 0, 32'h0,    32'h0};

    iSysRst = 1'b1; iSRd = '0; iSAdrs = '0; iSCmd = '0; iSDLen = '0; iSRdVd = 0; iMUfiRdy = 0;
    modelReset();
    repeat (2) @(negedge iSysClk);
    checkOut();
    chk("rst_wd", oMUfiWd, 32'h0);
    chk("rst_adrs", oMUfiAdrs, 32'h0);
    iSysRst = 1'b0;

    // Table-driven: basic burst and ignored strobes.
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].vd, tbl[i].cmd, tbl[i].dlen, tbl[i].adrs, tbl[i].rd, tbl[i].rdy);
      chk($sformatf("tbl%0d_wed", i), oMUfiWEd, tbl[i].eWEd);
      chk($sformatf("tbl%0d_wvd", i), oMUfiWVd, tbl[i].eWVd);
      chk($sformatf("tbl%0d_done", i), oSDone, tbl[i].eDone);
      if (tbl[i].eWEd) begin
        chk($sformatf("tbl%0d_adrs", i), oMUfiAdrs, tbl[i].eAdrs);
        chk($sformatf("tbl%0d_wd", i), oMUfiWd, tbl[i].eWd);
      end
    end
    chk("t1_xfers", logAdrs.size(), 4);

    // Stalled burst of three: ready pattern 1,0,0,1,...
    b = logAdrs.size();
    tick(1, 2'b11, 3, 32'h2000, 32'hB0, 0);
    tick(1, 2'b11, 3, 32'h0, 32'hB1, 1);
    tick(1, 2'b11, 3, 32'h0, 32'hB2, 0);
    tick(0, 2'b11, 3, 32'h0, 32'h0, 0);
    tick(0, 2'b11, 3, 32'h0, 32'h0, 1);
    tick(0, 2'b11, 3, 32'h0, 32'h0, 0);
    finishBurst("t2");
    chk("t2_xfers", logAdrs.size() - b, 3);
    for (int i = 0; i < 3; i++) begin
      if (b + i < logAdrs.size()) begin
        chk($sformatf("t2_adrs%0d", i), logAdrs[b+i], 32'h2000 + 32'(4 * i));
        chk($sformatf("t2_data%0d", i), logData[b+i], 32'hB0 + 32'(i));
      end
    end

    // Overflow: ten words into a depth-8 buffer with ready low.
    b = logAdrs.size();
    d0 = doneCnt;
    for (int i = 0; i < 10; i++) begin
      tick(1, 2'b11, 10, 32'h3000, 32'hC0 + 32'(i), 0);
      if (i == 7) chk("t3_ovf_before", oSOvf, 1'b0);
      if (i == 8) chk("t3_ovf_after9", oSOvf, 1'b1);
    end
    finishBurst("t3");
    chk("t3_xfers", logAdrs.size() - b, 8);
    chk("t3_done", doneCnt - d0, 1);
    if (logData.size() > 0) chk("t3_lastdata", logData[logData.size()-1], 32'hC7);

    // Abort: three of six words, then SPI released.
    d0 = doneCnt;
    for (int i = 0; i < 3; i++) tick(1, 2'b11, 6, 32'h4000, 32'hD0 + 32'(i), 0);
    tick(0, 2'b11, 0, 32'h0, 32'h0, 0);
    chk("t4_err", oSErr, 1'b1);
    chk("t4_wed_off", oMUfiWEd, 1'b0);
    chk("t4_busy_abort", oSBusy, 1'b1);
    tick(0, 2'b11, 0, 32'h0, 32'h0, 0);
    chk("t4_idle", oSBusy, 1'b0);
    chk("t4_nodone", doneCnt - d0, 0);
    tick(1, 2'b11, 1, 32'h4100, 32'hD9, 1);
    chk("t4_err_cleared", oSErr, 1'b0);
    finishBurst("t4");

    // Address wrap.
    b = logAdrs.size();
    tick(1, 2'b11, 2, 32'hFFFF_FFFC, 32'hE0, 1);
    tick(1, 2'b11, 2, 32'h0, 32'hE1, 1);
    finishBurst("t5");
    chk("t5_xfers", logAdrs.size() - b, 2);
    if (logAdrs.size() - b == 2) begin
      chk("t5_adrs0", logAdrs[b], 32'hFFFF_FFFC);
      chk("t5_adrs1", logAdrs[b+1], 32'h0000_0000);
    end

    // Asynchronous reset mid-burst.
    tick(1, 2'b11, 5, 32'h5000, 32'hF0, 0);
    tick(1, 2'b11, 5, 32'h0, 32'hF1, 0);
    #2 iSysRst = 1'b1;
    #1;
    chk("t6_rst_wd", oMUfiWd, 32'h0);
    chk("t6_rst_adrs", oMUfiAdrs, 32'h0);
    chk("t6_rst_flags", {oMUfiWEd, oMUfiWVd, oSBusy, oSDone, oSOvf, oSErr}, 32'h0);
    modelReset();
    iSRdVd = 0; iSDLen = '0;
    @(negedge iSysClk);
    iSysRst = 1'b0;
    b = logAdrs.size();
    tick(1, 2'b11, 2, 32'h6000, 32'h61, 1);
    tick(1, 2'b11, 2, 32'h0, 32'h62, 1);
    finishBurst("t6");
    chk("t6_xfers", logAdrs.size() - b, 2);
    if (logAdrs.size() - b == 2) chk("t6_data1", logData[b+1], 32'h62);

    // Randomized bursts against the model.
    for (int k = 0; k < 40; k++) begin
      len  = $urandom_range(1, 12);
      base = $urandom;
      ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      tick(1, 2'b11, 16'(len), base, $urandom, $urandom_range(0, 1));
      n = 0;
      while (mSt != 0 && n < 300) begin
        vd = (mRx < mLen) && ($urandom_range(0, 2) != 0);
        if (ab > 0 && mRx >= ab)                       dl = '0;
        else if (mRx == mLen && $urandom_range(0, 1)) dl = '0;
        else                                           dl = 16'(len);
        tick(vd, ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b11, dl, $urandom, $urandom,
             $urandom_range(0, 1));
        n++;
      end
      checks++;
      if (mSt != 0) begin
        failures++;
        $display("FAIL rand%0d_timeout: burst open after %0d cycles", k, n);
        modelReset();
      end
      tick(0, 2'b11, 0, '0, '0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
